// File: rtl/vdma_axis_downsizer.sv
// vdma_axis_downsizer
//
// Splits the 64-bit AXI4-Stream from the VDMA MM2S pacing controller into a
// 32-bit stream, lower word first. The block also locks onto frame
// boundaries and checks each line length and the row count against the
// configuration inputs.
//
// Ports
//   s_axis_aclk     single clock for all logic
//   s_axis_aresetn  asynchronous active-low reset
//   cfg_line_beats  64-bit beats per line (>= 1)
//   cfg_rows        lines per frame (>= 1)
//   s_axis_*        64-bit input stream (tuser = SOF, tlast = EOL)
//   m_axis_*        32-bit output stream (tuser on lower SOF word,
//                   tlast on upper EOL word)
//   frame_locked    high while the frame FSM is in LOCKED
//   frame_done      one-cycle pulse when the last line of a frame is accepted
//   err_line        one-cycle pulse on a line-length mismatch
//   err_sof         one-cycle pulse on a tuser in the middle of a frame
//   err_cnt         saturating error event counter
//
// Build option
//   VDMA_DS_ERR_CNT_EN  when defined, err_cnt counts err_line + err_sof events
//                       and saturates at 0xFFFF. When undefined, err_cnt is
//                       tied to 0.

module vdma_axis_downsizer (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic [15:0] cfg_line_beats,
  input  logic [15:0] cfg_rows,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        frame_locked,
  output logic        frame_done,
  output logic        err_line,
  output logic        err_sof,
  output logic [15:0] err_cnt
);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] hold_q, hold_d;
  logic        hold_sof_q, hold_sof_d;
  logic        hold_eol_q, hold_eol_d;
  logic        hold_valid_q, hold_valid_d;
  logic        phase_q, phase_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        frame_done_q, frame_done_d;
  logic        err_line_q, err_line_d;
  logic        err_sof_q, err_sof_d;

  logic        accept;
  logic        out_hs;
  logic        load;
  logic [15:0] col_eff;
  logic [15:0] row_eff;

  // A new beat is taken only when the hold register is empty or its upper
  // word is leaving this cycle. Gating with reset keeps tready low while
  // reset is asserted.
  assign s_axis_tready = s_axis_aresetn && (!hold_valid_q || (phase_q && m_axis_tready));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign out_hs        = hold_valid_q && m_axis_tready;

  assign m_axis_tvalid = hold_valid_q;
  assign m_axis_tdata  = phase_q ? hold_q[63:32] : hold_q[31:0];
  assign m_axis_tuser  = hold_sof_q && !phase_q;
  assign m_axis_tlast  = hold_eol_q && phase_q;

  assign frame_locked  = (state_q == LOCKED);
  assign frame_done    = frame_done_q;
  assign err_line      = err_line_q;
  assign err_sof       = err_sof_q;

  // Frame FSM. A tuser beat restarts the position at (0,0) before the beat
  // itself is counted, so the same path covers the first SOF, a mid-frame
  // resync and a one-beat line that carries both tuser and tlast.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    err_line_d   = 1'b0;
    err_sof_d    = 1'b0;
    load         = 1'b0;
    col_eff      = col_q;
    row_eff      = row_q;

    if (accept && ((state_q == LOCKED) || s_axis_tuser)) begin
      load    = 1'b1;
      state_d = LOCKED;

      if (s_axis_tuser) begin
        if ((state_q == LOCKED) && ((col_q != 16'd0) || (row_q != 16'd0))) begin
          err_sof_d = 1'b1;
        end
        col_eff = 16'd0;
        row_eff = 16'd0;
      end

      if (s_axis_tlast) begin
        // 17-bit compare so a saturated column never matches by wrapping.
        if (({1'b0, col_eff} + 17'd1) != {1'b0, cfg_line_beats}) begin
          err_line_d = 1'b1;
        end
        col_d = 16'd0;
        row_d = row_eff + 16'd1;
        if (row_eff == (cfg_rows - 16'd1)) begin
          frame_done_d = 1'b1;
          state_d      = WAIT_SOF;
          row_d        = 16'd0;
        end
      end else begin
        col_d = (col_eff == 16'hFFFF) ? col_eff : (col_eff + 16'd1);
        row_d = row_eff;
      end
    end
  end

  // Hold register and word phase. A load always restarts at the lower word.
  // The phase-0 handshake can never coincide with a load because tready is
  // low in that case.
  always_comb begin
    hold_d       = hold_q;
    hold_sof_d   = hold_sof_q;
    hold_eol_d   = hold_eol_q;
    hold_valid_d = hold_valid_q;
    phase_d      = phase_q;

    if (load) begin
      hold_d       = s_axis_tdata;
      hold_sof_d   = s_axis_tuser;
      hold_eol_d   = s_axis_tlast;
      hold_valid_d = 1'b1;
      phase_d      = 1'b0;
    end else if (out_hs) begin
      if (phase_q) begin
        hold_valid_d = 1'b0;
        phase_d      = 1'b0;
      end else begin
        phase_d = 1'b1;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q      <= WAIT_SOF;
      hold_q       <= 64'd0;
      hold_sof_q   <= 1'b0;
      hold_eol_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      phase_q      <= 1'b0;
      col_q        <= 16'd0;
      row_q        <= 16'd0;
      frame_done_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_sof_q   <= hold_sof_d;
      hold_eol_q   <= hold_eol_d;
      hold_valid_q <= hold_valid_d;
      phase_q      <= phase_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      err_line_q   <= err_line_d;
      err_sof_q    <= err_sof_d;
    end
  end

`ifdef VDMA_DS_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic [16:0] err_sum;

  // The counter is fed from the next-state pulses so it steps in the same
  // cycle the err_* pulses become visible.
  assign err_sum = {1'b0, err_cnt_q} + {16'd0, err_line_d} + {16'd0, err_sof_d};

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vdma_axis_downsizer.sv
// Self-checking bench for vdma_axis_downsizer: per-cycle vector tables for
// the nominal, pre-SOF and one-beat-line cases, plus hand-written sequences
// for short line, mid-frame SOF, backpressure and reset mid-frame.

module tb_vdma_axis_downsizer;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] cfgLineBeats;
  logic [15:0] cfgRows;
  logic [63:0] sData;
  logic        sUser;
  logic        sLast;
  logic        sValid;
  logic        sReady;
  logic [31:0] mData;
  logic        mUser;
  logic        mLast;
  logic        mValid;
  logic        mReady;
  logic        mReadyDrv;
  logic        bpOn;
  logic        bpReady;
  logic        locked;
  logic        done;
  logic        errLine;
  logic        errSof;
  logic [15:0] errCnt;

`ifdef VDMA_DS_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  always #5 clk = ~clk;

  assign mReady = bpOn ? bpReady : mReadyDrv;

  vdma_axis_downsizer dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rstN),
    .cfg_line_beats (cfgLineBeats),
    .cfg_rows       (cfgRows),
    .s_axis_tdata   (sData),
    .s_axis_tuser   (sUser),
    .s_axis_tlast   (sLast),
    .s_axis_tvalid  (sValid),
    .s_axis_tready  (sReady),
    .m_axis_tdata   (mData),
    .m_axis_tuser   (mUser),
    .m_axis_tlast   (mLast),
    .m_axis_tvalid  (mValid),
    .m_axis_tready  (mReady),
    .frame_locked   (locked),
    .frame_done     (done),
    .err_line       (errLine),
    .err_sof        (errSof),
    .err_cnt        (errCnt)
  );

  typedef struct packed {
    logic        sReady;
    logic        mValid;
    logic [31:0] mData;
    logic        mUser;
    logic        mLast;
    logic        locked;
    logic        done;
    logic        errLine;
    logic        errSof;
  } outs_t;

  typedef struct {
    logic [15:0] cfgLine;
    logic [15:0] cfgRows;
    logic        sValid;
    logic [63:0] sData;
    logic        sUser;
    logic        sLast;
    logic        mReady;
    outs_t       exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] curLine;
  logic [15:0] curRows;

  int nVec = 0;
  int nMis = 0;

  // Output monitor: collects handshaken words, counts pulses and watches the
  // stall/ready rules. It is the only writer of these variables.
  logic [31:0] wordQ[$];
  logic        userQ[$];
  logic        lastQ[$];
  int          errLineCnt = 0;
  int          errSofCnt  = 0;
  int          doneCnt    = 0;
  int          readyViol  = 0;
  int          stabViol   = 0;
  logic        prevStall  = 1'b0;
  logic [33:0] prevOut    = 34'd0;

  always @(negedge clk) begin
    if (rstN) begin
      if (mValid && (wordQ.size() % 2 == 0) && sReady) readyViol++;
      if (prevStall && (!mValid || ({mData, mUser, mLast} != prevOut))) stabViol++;
      prevStall = mValid && !mReady;
      prevOut   = {mData, mUser, mLast};
      if (mValid && mReady) begin
        wordQ.push_back(mData);
        userQ.push_back(mUser);
        lastQ.push_back(mLast);
      end
      if (errLine) errLineCnt++;
      if (errSof)  errSofCnt++;
      if (done)    doneCnt++;
    end else begin
      prevStall = 1'b0;
    end
  end

  // m_axis_tready pattern 1,0,0,1 while backpressure is enabled.
  int bpIdx = 0;
  always @(posedge clk) begin
    #1;
    if (bpOn) begin
      bpReady = ((bpIdx % 4) == 0) || ((bpIdx % 4) == 3);
      bpIdx++;
    end else begin
      bpReady = 1'b1;
      bpIdx   = 0;
    end
  end

  function automatic logic [31:0] lo(input int k);
    logic [31:0] kk;
    kk = k;
    return 32'hA000_0000 | kk;
  endfunction

  function automatic logic [31:0] hi(input int k);
    logic [31:0] kk;
    kk = k;
    return 32'hB000_0000 | kk;
  endfunction

  function automatic logic [63:0] beatOf(input int k);
    return {hi(k), lo(k)};
  endfunction

  function automatic logic [55:0] allOuts();
    return {sReady, mValid, mData, mUser, mLast, locked, done, errLine, errSof, errCnt};
  endfunction

  function automatic void addVec(input logic v, input logic [63:0] d, input logic u,
                                 input logic l, input logic mr, input logic sR,
                                 input logic mV, input logic [31:0] md, input logic mu,
                                 input logic ml, input logic lk, input logic dn,
                                 input logic el, input logic es);
    vec_t r;
    r.cfgLine = curLine;
    r.cfgRows = curRows;
    r.sValid  = v;
    r.sData   = d;
    r.sUser   = u;
    r.sLast   = l;
    r.mReady  = mr;
    r.exp     = '{sR, mV, md, mu, ml, lk, dn, el, es};
    vecs.push_back(r);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one table row, compares at the falling edge, then steps a cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    outs_t act;
    outs_t exp;
    cfgLineBeats = v.cfgLine;
    cfgRows      = v.cfgRows;
    sValid       = v.sValid;
    sData        = v.sData;
    sUser        = v.sUser;
    sLast        = v.sLast;
    mReadyDrv    = v.mReady;
    @(negedge clk);
    act = {sReady, mValid, mData, mUser, mLast, locked, done, errLine, errSof};
    exp = v.exp;
    if (!exp.mValid) begin
      act.mData = '0; act.mUser = 1'b0; act.mLast = 1'b0;
      exp.mData = '0; exp.mUser = 1'b0; exp.mLast = 1'b0;
    end
    checkOutput($sformatf("vec%0d", idx), {23'd0, act}, {23'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic [63:0] d, input logic u, input logic l);
    logic ok;
    ok     = 1'b0;
    sValid = 1'b1;
    sData  = d;
    sUser  = u;
    sLast  = l;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (sReady) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    sValid = 1'b0;
    nVec++;
    if (!ok) begin
      nMis++;
      $display("[TB] FAIL sendBeat: got no tready expected tready within 50 cycles");
    end
  endtask

  task automatic waitIdle(input string name);
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 200 && !idle; n++) begin
      @(negedge clk);
      if (!mValid) idle = 1'b1;
    end
    nVec++;
    if (!idle) begin
      nMis++;
      $display("[TB] FAIL %s: got tvalid stuck high expected idle within 200 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  // Checks the words emitted since baseW: beat k gives lo(k) then hi(k).
  task automatic checkFrameWords(input string name, input int baseW, input int nBeats,
                                 input int sofA, input int sofB, input int lastA, input int lastB);
    int n;
    n = wordQ.size() - baseW;
    checkOutput({name, "Count"}, 64'(n), 64'(2 * nBeats));
    for (int w = 0; w < 2 * nBeats && w < n; w++) begin
      logic [31:0] ed;
      logic        eu;
      logic        el;
      ed = (w % 2 == 0) ? lo(w / 2) : hi(w / 2);
      eu = (w == sofA) || (w == sofB);
      el = (w == lastA) || (w == lastB);
      checkOutput($sformatf("%sWord%0d", name, w),
                  {30'd0, wordQ[baseW + w], userQ[baseW + w], lastQ[baseW + w]},
                  {30'd0, ed, eu, el});
    end
  endtask

  localparam logic [63:0] Garbage = 64'hDEAD_BEEF_0BAD_F00D;

  initial begin
    int baseW;
    int baseLine;
    int baseSof;
    int baseDone;

    // Vector tables. Columns: valid, data, tuser, tlast, m_tready |
    // expected tready, m_tvalid, m_tdata, m_tuser, m_tlast, locked, done,
    // err_line, err_sof.

    // Nominal frame, 4 beats x 2 lines, continuous input and m_tready=1.
    curLine = 16'd4; curRows = 16'd2;
    addVec(1, beatOf(0), 1, 0, 1,  1, 0, 32'd0, 0, 0,  0, 0, 0, 0);
    addVec(1, beatOf(1), 0, 0, 1,  0, 1, lo(0), 1, 0,  1, 0, 0, 0);
    addVec(1, beatOf(1), 0, 0, 1,  1, 1, hi(0), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(2), 0, 0, 1,  0, 1, lo(1), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(2), 0, 0, 1,  1, 1, hi(1), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(3), 0, 1, 1,  0, 1, lo(2), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(3), 0, 1, 1,  1, 1, hi(2), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(4), 0, 0, 1,  0, 1, lo(3), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(4), 0, 0, 1,  1, 1, hi(3), 0, 1,  1, 0, 0, 0);
    addVec(1, beatOf(5), 0, 0, 1,  0, 1, lo(4), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(5), 0, 0, 1,  1, 1, hi(4), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(6), 0, 0, 1,  0, 1, lo(5), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(6), 0, 0, 1,  1, 1, hi(5), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(7), 0, 1, 1,  0, 1, lo(6), 0, 0,  1, 0, 0, 0);
    addVec(1, beatOf(7), 0, 1, 1,  1, 1, hi(6), 0, 0,  1, 0, 0, 0);
    addVec(0, 64'd0,     0, 0, 1,  0, 1, lo(7), 0, 0,  0, 1, 0, 0);
    addVec(0, 64'd0,     0, 0, 1,  1, 1, hi(7), 0, 1,  0, 0, 0, 0);
    addVec(0, 64'd0,     0, 0, 1,  1, 0, 32'd0, 0, 0,  0, 0, 0, 0);

    // Pre-SOF garbage (one with tlast) is swallowed, then a 2x1 frame.
    curLine = 16'd2; curRows = 16'd1;
    addVec(1, Garbage,   0, 0, 1,  1, 0, 32'd0, 0, 0,  0, 0, 0, 0);
    addVec(1, Garbage,   0, 0, 1,  1, 0, 32'd0, 0, 0,  0, 0, 0, 0);
    addVec(1, Garbage,   0, 1, 1,  1, 0, 32'd0, 0, 0,  0, 0, 0, 0);
    addVec(1, beatOf(0), 1, 0, 1,  1, 0, 32'd0, 0, 0,  0, 0, 0, 0);
    addVec(1, beatOf(1), 0, 1, 1,  0, 1, lo(0), 1, 0,  1, 0, 0, 0);
    addVec(1, beatOf(1), 0, 1, 1,  1, 1, hi(0), 0, 0,  1, 0, 0, 0);
    addVec(0, 64'd0,     0, 0, 1,  0, 1, lo(1), 0, 0,  0, 1, 0, 0);
    addVec(0, 64'd0,     0, 0, 1,  1, 1, hi(1), 0, 1,  0, 0, 0, 0);
    addVec(0, 64'd0,     0, 0, 1,  1, 0, 32'd0, 0, 0,  0, 0, 0, 0);

    // One-beat frame (tuser+tlast) with stalls on both words.
    curLine = 16'd1; curRows = 16'd1;
    addVec(1, beatOf(9), 1, 1, 1,  1, 0, 32'd0, 0, 0,  0, 0, 0, 0);
    addVec(0, 64'd0,     0, 0, 0,  0, 1, lo(9), 1, 0,  0, 1, 0, 0);
    addVec(0, 64'd0,     0, 0, 1,  0, 1, lo(9), 1, 0,  0, 0, 0, 0);
    addVec(0, 64'd0,     0, 0, 0,  0, 1, hi(9), 0, 1,  0, 0, 0, 0);
    addVec(0, 64'd0,     0, 0, 1,  1, 1, hi(9), 0, 1,  0, 0, 0, 0);
    addVec(0, 64'd0,     0, 0, 1,  1, 0, 32'd0, 0, 0,  0, 0, 0, 0);

    rstN = 1'b0; sValid = 1'b0; sData = 64'd0; sUser = 1'b0; sLast = 1'b0;
    mReadyDrv = 1'b1; bpOn = 1'b0; cfgLineBeats = 16'd4; cfgRows = 16'd2;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetHeld", {8'd0, allOuts()}, 64'd0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("resetRelease", {8'd0, allOuts()}, {8'd0, 1'b1, 55'd0});
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Short line: line 0 ends after 3 beats, line 1 has the full 4.
    cfgLineBeats = 16'd4; cfgRows = 16'd2;
    baseW = wordQ.size(); baseLine = errLineCnt; baseSof = errSofCnt; baseDone = doneCnt;
    sendBeat(beatOf(0), 1, 0);
    sendBeat(beatOf(1), 0, 0);
    sendBeat(beatOf(2), 0, 1);
    sendBeat(beatOf(3), 0, 0);
    sendBeat(beatOf(4), 0, 0);
    sendBeat(beatOf(5), 0, 0);
    sendBeat(beatOf(6), 0, 1);
    waitIdle("shortIdle");
    checkOutput("shortErrLine", 64'(errLineCnt - baseLine), 64'd1);
    checkOutput("shortErrSof", 64'(errSofCnt - baseSof), 64'd0);
    checkOutput("shortDone", 64'(doneCnt - baseDone), 64'd1);
    checkOutput("shortLocked", {63'd0, locked}, 64'd0);
    checkOutput("shortErrCnt", {48'd0, errCnt}, CntEn ? 64'd1 : 64'd0);
    checkFrameWords("short", baseW, 7, 0, -1, 5, 13);

    // Mid-frame SOF on beat 2 of line 0; the frame restarts there.
    baseW = wordQ.size(); baseLine = errLineCnt; baseSof = errSofCnt; baseDone = doneCnt;
    sendBeat(beatOf(0), 1, 0);
    sendBeat(beatOf(1), 0, 0);
    sendBeat(beatOf(2), 1, 0);
    sendBeat(beatOf(3), 0, 0);
    sendBeat(beatOf(4), 0, 0);
    sendBeat(beatOf(5), 0, 1);
    sendBeat(beatOf(6), 0, 0);
    sendBeat(beatOf(7), 0, 0);
    sendBeat(beatOf(8), 0, 0);
    sendBeat(beatOf(9), 0, 1);
    waitIdle("midSofIdle");
    checkOutput("midSofErrSof", 64'(errSofCnt - baseSof), 64'd1);
    checkOutput("midSofErrLine", 64'(errLineCnt - baseLine), 64'd0);
    checkOutput("midSofDone", 64'(doneCnt - baseDone), 64'd1);
    checkOutput("midSofLocked", {63'd0, locked}, 64'd0);
    checkOutput("midSofErrCnt", {48'd0, errCnt}, CntEn ? 64'd2 : 64'd0);
    checkFrameWords("midSof", baseW, 10, 0, 4, 11, 19);

    // Backpressure with m_tready cycling 1,0,0,1 on a 2x2 frame.
    cfgLineBeats = 16'd2; cfgRows = 16'd2;
    baseW = wordQ.size(); baseLine = errLineCnt; baseDone = doneCnt;
    bpOn = 1'b1;
    sendBeat(beatOf(0), 1, 0);
    sendBeat(beatOf(1), 0, 1);
    sendBeat(beatOf(2), 0, 0);
    sendBeat(beatOf(3), 0, 1);
    waitIdle("bpIdle");
    bpOn = 1'b0;
    checkFrameWords("bp", baseW, 4, 0, -1, 3, 7);
    checkOutput("bpReadyRule", 64'(readyViol), 64'd0);
    checkOutput("bpStable", 64'(stabViol), 64'd0);
    checkOutput("bpDone", 64'(doneCnt - baseDone), 64'd1);
    checkOutput("bpErrLine", 64'(errLineCnt - baseLine), 64'd0);

    // Reset mid-frame, after word 5 has been taken.
    cfgLineBeats = 16'd4; cfgRows = 16'd2;
    baseW = wordQ.size();
    sendBeat(beatOf(0), 1, 0);
    sendBeat(beatOf(1), 0, 0);
    sendBeat(beatOf(2), 0, 0);
    sendBeat(beatOf(3), 0, 0);
    checkOutput("preResetWords", 64'(wordQ.size() - baseW), 64'd6);
    rstN = 1'b0;
    #1;
    checkOutput("resetMidOuts", {8'd0, allOuts()}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("resetMidRelease", {8'd0, allOuts()}, {8'd0, 1'b1, 55'd0});
    @(posedge clk);
    #1;
    baseW = wordQ.size();
    sendBeat(beatOf(5), 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postResetDiscard", 64'(wordQ.size() - baseW), 64'd0);
    checkOutput("postResetUnlocked", {62'd0, locked, mValid}, 64'd0);
    sendBeat(beatOf(6), 1, 0);
    @(negedge clk);
    checkOutput("postResetSof", {29'd0, locked, mValid, mData, mUser},
                {29'd0, 1'b1, 1'b1, lo(6), 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/vdma_axis_downsizer.md
# vdma_axis_downsizer

Downstream stage of the VDMA MM2S pacing controller. Consumes its 64-bit AXI4-Stream video (tuser = start of frame, tlast = end of line) and re-emits it as a 32-bit stream, lower word first. Locks to frame boundaries and checks line length and row count against configuration. Reports framing errors as one-cycle pulses.

## Interface
Parameters:
- none. Widths are fixed at 64 bits in and 32 bits out.

Ports:
- s_axis_aclk  in  1  single clock for all logic
- s_axis_aresetn  in  1  reset; asynchronous, active-low
- cfg_line_beats  in  16  64-bit beats per line; must be ≥1
- cfg_rows  in  16  lines per frame; must be ≥1
- s_axis_tdata  in  64  input pixel data
- s_axis_tuser  in  1  start of frame; marks the first beat of line 0
- s_axis_tlast  in  1  end of line
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  32  output data
- m_axis_tuser  out  1  start of frame, on the lower word of the SOF beat
- m_axis_tlast  out  1  end of line, on the upper word of the EOL beat
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- frame_locked  out  1  high while in state LOCKED
- frame_done  out  1  one-cycle pulse: last line of the frame accepted
- err_line  out  1  one-cycle pulse: line length mismatch
- err_sof  out  1  one-cycle pulse: unexpected tuser
- err_cnt  out  16  error event counter (see Configuration)

## Operation
Input acceptance:
- A beat is accepted when s_axis_tvalid && s_axis_tready.

Holding register:
- State: hold[63:0], hold_sof, hold_eol, hold_valid, phase.
- s_axis_tready = !hold_valid || (phase && m_axis_tready).
- Output fields:
  - m_axis_tvalid = hold_valid.
  - m_axis_tdata = phase ? hold[63:32] : hold[31:0].
  - m_axis_tuser = hold_sof && !phase.
  - m_axis_tlast = hold_eol && phase.
- phase toggles on each output handshake.
- When phase is 1 and the output handshake occurs, hold_valid clears unless a new beat is accepted in the same cycle.
- When a new beat is loaded, phase returns to 0.

Frame FSM, two states:
- **WAIT_SOF** (reset state):
  - Beats with tuser=0 are accepted and discarded. They are not loaded and no error is raised.
  - A beat with tuser=1 is loaded; col and row are set from that beat; go to LOCKED.
- **LOCKED**:
  - Every accepted beat is loaded.
  - col is a 16-bit count that increments per beat and saturates at 0xFFFF.
  - On tlast: if col+1 ≠ cfg_line_beats, pulse err_line. Then col←0 and row←row+1.
  - tlast while row == cfg_rows−1: pulse frame_done and go to WAIT_SOF.
  - tuser=1 with (col,row) ≠ (0,0): pulse err_sof. The beat is loaded as a new SOF, col and row restart, and the state stays LOCKED.
- A beat carrying both tuser and tlast is legal; it is a one-beat line.
- Line-length errors do not drop data and do not unlock.

## Timing
- Latency: a beat accepted in cycle N is visible on m_axis in cycle N+1 (lower word).
- Throughput: one 64-bit beat per 2 cycles with m_axis_tready held high, zero bubbles between beats.
- Handshakes:
  - m_axis_tvalid never drops without a handshake.
  - m_axis_tdata/tuser/tlast are stable while stalled.
- Pulses:
  - err_line, err_sof and frame_done are registered and asserted in cycle N+1 for the beat accepted in cycle N.
  - All three may assert in the same cycle.
- Reset values:
  - All outputs 0, except s_axis_tready, which is 1 in the first cycle after reset release.
  - hold_valid=0, phase=0, col=0, row=0, state WAIT_SOF.
- Reset asserted mid-frame: any half-emitted beat is dropped; the block resumes in WAIT_SOF.
- cfg_line_beats and cfg_rows are sampled continuously. They must only change while frame_locked=0.

## Configuration
- Macro: VDMA_DS_ERR_CNT_EN.
- Defined: err_cnt increments by the number of error events (err_line + err_sof, 0–2) each cycle. It saturates at 0xFFFF and is cleared only by reset.
- Undefined: the counter logic is not built and err_cnt is tied to 0.

## Test plan
- **Nominal frame.** cfg_line_beats=4, cfg_rows=2, SOF then 8 beats with m_axis_tready=1.
  - 16 output words, lower word first.
  - tuser on word 0 only; tlast on words 7 and 15.
  - frame_done one cycle after the 8th beat is accepted; no errors.
- **Pre-SOF garbage.** 3 beats with tuser=0, then a valid frame.
  - The 3 beats are discarded, with no output and no errors.
  - frame_locked rises the cycle after the SOF beat is accepted.
- **Short line.** cfg_line_beats=4, line 0 ends with tlast on beat 3.
  - err_line pulses once.
  - Line 1 is counted from col=0.
  - err_cnt=1 with the macro defined, 0 without.
- **Mid-frame SOF.** tuser on beat 2 of line 0.
  - err_sof pulses.
  - The output carries tuser on that beat's lower word.
  - The frame completes 8 beats after it.
- **Backpressure.** m_axis_tready toggles 1,0,0,1 repeatedly.
  - Word order and data are preserved.
  - s_axis_tready is low while hold is full and phase=0.
- **Reset mid-frame.** Assert s_axis_aresetn low after word 5.
  - All outputs go to 0 immediately.
  - After release, the block stays in WAIT_SOF until the next tuser.
